// File: rtl/fetch_stage_if.sv
// Signal bundle between the MIPS fetch stage and its surroundings:
// instruction memory port, hazard/redirect controls and the IF/ID register outputs.
interface fetch_stage_if;
    logic [31:0] im_pc;
    logic [31:0] im_code;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_code;
    logic        if_id_valid;
    logic        adr_err;
    logic [31:0] fetch_count;

    // Handshake: redirect_valid and stall are single-cycle qualifiers with no
    // ready; the fetch stage accepts them on every rising edge they are high.
    modport master (
        output im_pc,
        input  im_code,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        output if_id_pc,
        output if_id_pc4,
        output if_id_code,
        output if_id_valid,
        output adr_err,
        output fetch_count
    );

    modport slave (
        input  im_pc,
        output im_code,
        output stall,
        output redirect_valid,
        output redirect_target,
        input  if_id_pc,
        input  if_id_pc4,
        input  if_id_code,
        input  if_id_valid,
        input  adr_err,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register, stall and
// redirect handling with optional branch-delay slot, sticky misalignment flag.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter logic [31:0] NOP_CODE   = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_stage_if.master bus
);

    logic [31:0] pc_q,         pc_d;
    logic [31:0] ifid_pc_q,    ifid_pc_d;
    logic [31:0] ifid_pc4_q,   ifid_pc4_d;
    logic [31:0] ifid_code_q,  ifid_code_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        adr_err_q,    adr_err_d;
    logic [31:0] count_q,      count_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Priority: redirect beats stall beats normal advance; reset is applied in the register.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_code_d  = ifid_code_q;
        ifid_valid_d = ifid_valid_q;
        count_d      = count_q;
        adr_err_d    = adr_err_q;

        if (bus.redirect_valid) begin
            pc_d       = {bus.redirect_target[31:2], 2'b00};
            ifid_pc_d  = pc_q;
            ifid_pc4_d = pc_plus4;
            if (bus.redirect_target[1:0] != 2'b00) begin
                adr_err_d = 1'b1;
            end
            if (DELAY_SLOT) begin
                ifid_code_d  = bus.im_code;
                ifid_valid_d = 1'b1;
                count_d      = count_q + 32'd1;
            end else begin
                ifid_code_d  = NOP_CODE;
                ifid_valid_d = 1'b0;
            end
        end else if (!bus.stall) begin
            pc_d         = pc_plus4;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_code_d  = bus.im_code;
            ifid_valid_d = 1'b1;
            count_d      = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_code_q  <= NOP_CODE;
            ifid_valid_q <= 1'b0;
            adr_err_q    <= 1'b0;
            count_q      <= 32'h0000_0000;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_code_q  <= ifid_code_d;
            ifid_valid_q <= ifid_valid_d;
            adr_err_q    <= adr_err_d;
            count_q      <= count_d;
        end
    end

    assign bus.im_pc       = pc_q;
    assign bus.if_id_pc    = ifid_pc_q;
    assign bus.if_id_pc4   = ifid_pc4_q;
    assign bus.if_id_code  = ifid_code_q;
    assign bus.if_id_valid = ifid_valid_q;
    assign bus.adr_err     = adr_err_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (no delay slot / delay slot) share stimulus,
// checked every cycle against an abstract fetch model plus directed literal checks.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] mem [1024];

    int checks = 0;
    int errors = 0;

    fetch_stage_if bus0 ();
    fetch_stage_if bus1 ();

    assign bus0.stall           = stall;
    assign bus0.redirect_valid  = rv;
    assign bus0.redirect_target = tgt;
    assign bus0.im_code         = mem[bus0.im_pc[11:2]];
    assign bus1.stall           = stall;
    assign bus1.redirect_valid  = rv;
    assign bus1.redirect_target = tgt;
    assign bus1.im_code         = mem[bus1.im_pc[11:2]];

    fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0), .NOP_CODE(NOP)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.master));
    fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1), .NOP_CODE(NOP)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.master));

    // Observed outputs, indexed by instance (0 = no delay slot, 1 = delay slot)
    logic [31:0] o_im_pc [2];
    logic [31:0] o_pc    [2];
    logic [31:0] o_pc4   [2];
    logic [31:0] o_code  [2];
    logic        o_valid [2];
    logic        o_adr   [2];
    logic [31:0] o_cnt   [2];

    assign o_im_pc[0] = bus0.im_pc;       assign o_im_pc[1] = bus1.im_pc;
    assign o_pc[0]    = bus0.if_id_pc;    assign o_pc[1]    = bus1.if_id_pc;
    assign o_pc4[0]   = bus0.if_id_pc4;   assign o_pc4[1]   = bus1.if_id_pc4;
    assign o_code[0]  = bus0.if_id_code;  assign o_code[1]  = bus1.if_id_code;
    assign o_valid[0] = bus0.if_id_valid; assign o_valid[1] = bus1.if_id_valid;
    assign o_adr[0]   = bus0.adr_err;     assign o_adr[1]   = bus1.adr_err;
    assign o_cnt[0]   = bus0.fetch_count; assign o_cnt[1]   = bus1.fetch_count;

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what each instance must hold after every edge
    logic [31:0] m_pc    [2];
    logic [31:0] m_ipc   [2];
    logic [31:0] m_ipc4  [2];
    logic [31:0] m_code  [2];
    logic        m_valid [2];
    logic        m_adr   [2];
    logic [31:0] m_cnt   [2];
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_pc[d] = 32'h0; m_ipc[d] = 32'h0; m_ipc4[d] = 32'h0;
                m_code[d] = NOP; m_valid[d] = 1'b0; m_adr[d] = 1'b0; m_cnt[d] = 32'h0;
            end else if (rv) begin
                m_ipc[d]  = m_pc[d];
                m_ipc4[d] = m_pc[d] + 32'd4;
                if (tgt % 4 != 0) m_adr[d] = 1'b1;
                if (d == 1) begin
                    m_code[d]  = mem[(m_pc[d] / 4) % 1024];
                    m_valid[d] = 1'b1;
                    m_cnt[d]   = m_cnt[d] + 1;
                end else begin
                    m_code[d]  = NOP;
                    m_valid[d] = 1'b0;
                end
                m_pc[d] = tgt - (tgt % 4);
            end else if (!stall) begin
                m_ipc[d]   = m_pc[d];
                m_ipc4[d]  = m_pc[d] + 32'd4;
                m_code[d]  = mem[(m_pc[d] / 4) % 1024];
                m_valid[d] = 1'b1;
                m_cnt[d]   = m_cnt[d] + 1;
                m_pc[d]    = m_pc[d] + 32'd4;
            end
        end
        if (rst) model_ok = 1'b1;
    end

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Scoreboard compare process: every cycle once the model is defined
    always @(negedge clk) begin
        if (model_ok) begin
            for (int d = 0; d < 2; d++) begin
                check("im_pc",       d, o_im_pc[d],        m_pc[d]);
                check("if_id_pc",    d, o_pc[d],           m_ipc[d]);
                check("if_id_pc4",   d, o_pc4[d],          m_ipc4[d]);
                check("if_id_code",  d, o_code[d],         m_code[d]);
                check("if_id_valid", d, {31'h0, o_valid[d]}, {31'h0, m_valid[d]});
                check("adr_err",     d, {31'h0, o_adr[d]},   {31'h0, m_adr[d]});
                check("fetch_count", d, o_cnt[d],          m_cnt[d]);
            end
        end
    end

    // Driver: advance one edge, return at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rv = 1'b0; tgt = 32'h0;
        for (int k = 0; k < 1024; k++) mem[k] = 32'h1000 + k;
        @(negedge clk);
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            check("rst im_pc", d, o_im_pc[d], 32'h0);
            check("rst valid", d, {31'h0, o_valid[d]}, 32'h0);
            check("rst count", d, o_cnt[d], 32'h0);
            check("rst code",  d, o_code[d], NOP);
            check("rst pc4",   d, o_pc4[d], 32'h0);
        end

        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                check("run pc",    d, o_pc[d], 32'(k * 4));
                check("run code",  d, o_code[d], 32'(32'h1000 + k));
                check("run count", d, o_cnt[d], 32'(k + 1));
                check("run valid", d, {31'h0, o_valid[d]}, 32'h1);
            end
        end

        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                check("stall pc",    d, o_pc[d], 32'h8);
                check("stall im_pc", d, o_im_pc[d], 32'hC);
                check("stall count", d, o_cnt[d], 32'd3);
            end
        end
        stall = 1'b0;
        step();
        for (int d = 0; d < 2; d++) check("resume pc", d, o_pc[d], 32'hC);

        rv = 1'b1; tgt = 32'h40; stall = 1'b1;
        step();
        rv = 1'b0; stall = 1'b0;
        check("ds0 valid", 0, {31'h0, o_valid[0]}, 32'h0);
        check("ds0 code",  0, o_code[0], NOP);
        check("ds0 pc",    0, o_pc[0], 32'h10);
        check("ds0 im_pc", 0, o_im_pc[0], 32'h40);
        check("ds0 count", 0, o_cnt[0], 32'd4);
        check("ds1 valid", 1, {31'h0, o_valid[1]}, 32'h1);
        check("ds1 code",  1, o_code[1], 32'h1004);
        check("ds1 pc",    1, o_pc[1], 32'h10);
        check("ds1 im_pc", 1, o_im_pc[1], 32'h40);
        check("ds1 count", 1, o_cnt[1], 32'd5);
        step();
        for (int d = 0; d < 2; d++) begin
            check("target pc",    d, o_pc[d], 32'h40);
            check("target valid", d, {31'h0, o_valid[d]}, 32'h1);
            check("target code",  d, o_code[d], 32'h1010);
        end

        rv = 1'b1; tgt = 32'h42;
        step();
        rv = 1'b0;
        for (int d = 0; d < 2; d++) check("misalign im_pc", d, o_im_pc[d], 32'h40);
        for (int k = 0; k < 11; k++) begin
            for (int d = 0; d < 2; d++) check("adr_err sticky", d, {31'h0, o_adr[d]}, 32'h1);
            if (k < 10) step();
        end

        rv = 1'b1; tgt = 32'hFFFF_FFFC;
        step();
        rv = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            check("wrap im_pc", d, o_im_pc[d], 32'h0);
            check("wrap pc4",   d, o_pc4[d], 32'h0);
            check("wrap pc",    d, o_pc[d], 32'hFFFF_FFFC);
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) check("adr_err cleared", d, {31'h0, o_adr[d]}, 32'h0);

        for (int k = 0; k < 1024; k++) mem[k] = $urandom;
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 25);
            rv    = ($urandom_range(0, 99) < 15);
            tgt   = $urandom;
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            step();
        end
        rst = 1'b0; stall = 1'b0; rv = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction word into the IF/ID pipeline register. Handles hazard stalls and control-flow redirects from later stages, with optional MIPS branch-delay-slot semantics, and keeps a sticky misaligned-target flag and a retired-fetch counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DELAY_SLOT, 1, 1 = the instruction fetched in the redirect cycle enters IF/ID; 0 = it is squashed.
- NOP_CODE, 32'h0000_0000, instruction word inserted for a bubble (sll $0,$0,0).

Ports:
- clk  in  1  Clock. All state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- im_pc  out  32  Address to instruction memory. Equals the PC register, combinationally.
- im_code  in  32  Instruction word from memory for im_pc, valid in the same cycle.
- stall  in  1  Hold PC and IF/ID (load-use hazard).
- redirect_valid  in  1  Control transfer resolved this cycle.
- redirect_target  in  32  New PC when redirect_valid=1.
- if_id_pc  out  32  PC of the instruction held in IF/ID.
- if_id_pc4  out  32  if_id_pc + 4, modulo 2^32.
- if_id_code  out  32  Instruction word held in IF/ID.
- if_id_valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- adr_err  out  1  Sticky flag: a misaligned redirect_target has been seen.
- fetch_count  out  32  Number of valid instructions loaded into IF/ID. Wraps modulo 2^32.

## Operation
- Reset has priority over all other inputs. On reset: pc=RESET_PC, if_id_pc=0, if_id_pc4=0, if_id_code=NOP_CODE, if_id_valid=0, adr_err=0, fetch_count=0.
- The per-cycle action is chosen by priority: rst > redirect_valid > stall > normal advance.
- Normal advance: pc <= pc+4. IF/ID <= {pc, pc+4, im_code, valid=1}. fetch_count += 1.
- Stall, with no redirect: pc, IF/ID and fetch_count hold their values.
- Redirect, which wins over a simultaneous stall:
  - pc <= {redirect_target[31:2], 2'b00}.
  - If redirect_target[1:0] != 0, set adr_err to 1. It stays 1 until reset.
  - With DELAY_SLOT=1: IF/ID <= {pc, pc+4, im_code, 1} and fetch_count += 1. This is the delay-slot instruction.
  - With DELAY_SLOT=0: IF/ID <= {pc, pc+4, NOP_CODE, 0}. fetch_count holds.
- All PC arithmetic is 32-bit unsigned. pc=32'hFFFF_FFFC advances to 32'h0000_0000. Memory indexing uses im_pc[11:2]; this block does not bound-check it.
- if_id_pc and if_id_pc4 of a bubble still carry the squashed PC. Downstream must qualify on if_id_valid.

## Timing
- im_pc changes only after a clock edge. im_code is sampled in the same cycle, so there is zero extra fetch latency.
- Instruction at address A appears on if_id_* one cycle after im_pc=A, on the edge that advances PC.
- After a redirect edge, im_pc = target on the next cycle. The target instruction reaches IF/ID one edge later.
  - DELAY_SLOT=0: a redirect costs exactly one bubble cycle.
  - DELAY_SLOT=1: a redirect costs zero bubble cycles.
- A stall asserted for N cycles holds IF/ID for N cycles. Advance resumes on the first edge with stall=0.
- Deasserting rst: the first edge with rst=0 loads the instruction at RESET_PC into IF/ID. The first valid=1 is seen in the cycle after that edge.
- Reset mid-redirect or mid-stall: reset wins, and all in-flight state is discarded.

## Test plan
- Reset then free-run with IM words 0x1000+k at word k, for 3 cycles after rst falls.
  - Required: if_id_pc = 0x0, 0x4, 0x8.
  - Required: if_id_code = 0x1000, 0x1001, 0x1002.
  - Required: fetch_count = 1, 2, 3, with if_id_valid=1 throughout.
- Stall held for 2 cycles while IF/ID holds pc=0x8.
  - Required: IF/ID and im_pc=0xC are unchanged for 2 cycles, and fetch_count does not increment.
  - Required: the next edge loads pc=0xC.
- DELAY_SLOT=0, redirect to 0x40 while im_pc=0x10.
  - Required: next cycle if_id_valid=0, if_id_code=NOP_CODE, if_id_pc=0x10, im_pc=0x40.
  - Required: the following edge gives if_id_pc=0x40 with valid=1.
- DELAY_SLOT=1, redirect to 0x40 with stall=1 in the same cycle while im_pc=0x10.
  - Required: IF/ID takes pc=0x10 with valid=1, fetch_count increments, and im_pc=0x40 next cycle.
- Redirect to 0x42.
  - Required: im_pc=0x40 and adr_err=1, staying set across 10 further cycles until rst.
- Force pc to 0xFFFF_FFFC via redirect, then advance.
  - Required: im_pc=0x0 and if_id_pc4=0x0.
